iob_vexriscv_dbus_bridge: RTL
=============================

// Module: iob_vexriscv_dbus_bridge
// PURPOSE
//  Converts the VexRiscv simple dBus (stream cmd/rsp) to the IOb native bus (valid/addr/wdata/wstrb -> ready/rdata).
//  Sits between the VexRiscv core data port and the IOb interconnect.
//  Gives correct command back-pressure and one outstanding access at a time.
//  Adds a bus-timeout watchdog so a dead slave cannot hang the core.
// PARAMETERS
//  ADDR_W     32  address width
//  DATA_W     32  data width, multiple of 8
//  TIMEOUT_W  10  watchdog counter width; timeout after 2**TIMEOUT_W-1 wait cycles; 0 disables the watchdog
// PORTS
//  clk             in   1         clock
//  rst             in   1         synchronous, active-low reset
//  cmd_valid       in   1         VexRiscv dBus_cmd_valid
//  cmd_ready       out  1         dBus_cmd_ready
//  cmd_wr          in   1         1 = write, 0 = read
//  cmd_address     in   ADDR_W    byte address
//  cmd_data        in   DATA_W    write data
//  cmd_mask        in   DATA_W/8  byte enables
//  rsp_valid       out  1         dBus_rsp_valid; asserted for reads only
//  rsp_data        out  DATA_W    read data
//  rsp_error       out  1         read aborted by timeout
//  iob_valid       out  1         IOb request valid
//  iob_addr        out  ADDR_W    IOb address
//  iob_wdata       out  DATA_W    IOb write data
//  iob_wstrb       out  DATA_W/8  IOb write strobe; 0 for reads
//  iob_ready       in   1         IOb completion strobe (read and write)
//  iob_rdata       in   DATA_W    IOb read data, valid with iob_ready
//  timeout_o       out  1         one-cycle pulse on watchdog expiry
// BEHAVIOUR
//  Reset (rst==0 at a clk edge) forces:
//   - FSM to IDLE
//   - cmd_ready=1 from the following cycle
//   - iob_valid=0, iob_addr/iob_wdata/iob_wstrb=0
//   - rsp_valid=0, rsp_data=0, rsp_error=0, timeout_o=0
//   - watchdog=0
//  Reset mid-access drops the access; no rsp is issued for it.
//  FSM states:
//   - IDLE: cmd_ready=1. On cmd_valid: latch addr, wdata, wstrb (mask if wr, else 0) and wr; go to BUSY.
//   - BUSY: iob_valid=1 and held stable.
//     - On iob_ready: complete the access. A read also latches iob_rdata.
//     - On watchdog expiry: complete the access with error.
//  cmd_ready = IDLE | (BUSY & iob_ready & ~expiry).
//   - A cmd accepted on the completion cycle re-latches and stays in BUSY: back-to-back accesses, no bubble on the cmd side.
//   - iob_valid stays high continuously; iob_addr/iob_wdata/iob_wstrb change on that edge.
//  Latency:
//   - cmd accepted at edge N -> iob_valid=1 in cycle N+1.
//   - iob_ready in cycle M -> read: rsp_valid=1 in cycle M+1 for exactly one cycle, rsp_data=latched rdata, rsp_error=0.
//   - Writes produce no rsp.
//  Watchdog:
//   - Clears on entering BUSY; increments each BUSY cycle without iob_ready; saturates.
//   - At all-ones: iob_valid drops next cycle and timeout_o pulses for one cycle.
//   - Read: rsp_valid=1, rsp_data=0, rsp_error=1. Write: silently dropped.
//   - FSM returns to IDLE.
//   - iob_ready and expiry in the same cycle: iob_ready wins, normal completion.
//  iob_ready while IDLE: ignored; no state change, no rsp.
//  rsp_valid has no back-pressure; the core always accepts.
// STRUCTURE
//  Shared header iob_vexriscv_bridge.vh:
//   - STATE_IDLE=1'b0, STATE_BUSY=1'b1
//   - RSP_ERR_NONE/RSP_ERR_TIMEOUT codes
//  Sub-module iob_bridge_watchdog:
//   - Inputs: clear/enable, saturating TIMEOUT_W counter.
//   - Output: expiry strobe; tied 0 when TIMEOUT_W==0.
//  Remainder is the FSM and request/response registers in this module.
// TESTING
//  1 Read: cmd rd addr=0x100; slave ready 3 cycles after iob_valid with rdata=0xDEADBEEF -> one rsp_valid, data=0xDEADBEEF, error=0.
//  2 Write: cmd wr addr=0x104 data=0x12345678 mask=4'b0011 -> iob_wstrb=0011, wdata held until ready; no rsp_valid.
//  3 Back-to-back: 4 reads with cmd_valid held and zero-wait slave -> iob_valid never drops; 4 rsp in order, cmd_ready low only while waiting.
//  4 Timeout: TIMEOUT_W=4, slave silent -> after 15 wait cycles timeout_o pulses, rsp_valid with error=1, data=0; next cmd proceeds normally.
//  5 Simultaneous: iob_ready on the expiry cycle -> normal rsp, error=0, no timeout_o.
//  6 Reset mid-read: rst=0 while BUSY -> next cycle iob_valid=0, cmd_ready=1; late iob_ready ignored, no rsp.

Source files
------------

// File: rtl/iob_vexriscv_dbus_bridge_pkg.sv
// Shared types and default widths for the VexRiscv dBus to IOb bridge.
//   ADDR_W_DEF / DATA_W_DEF / TIMEOUT_W_DEF : default parameter values
//   state_e   : bridge FSM state encoding
//   rsp_err_e : response error code driven on rsp_error
package iob_vexriscv_dbus_bridge_pkg;

    localparam int unsigned ADDR_W_DEF    = 32;
    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned TIMEOUT_W_DEF = 10;

    typedef enum logic {
        STATE_IDLE = 1'b0,
        STATE_BUSY = 1'b1
    } state_e;

    typedef enum logic {
        RSP_ERR_NONE    = 1'b0,
        RSP_ERR_TIMEOUT = 1'b1
    } rsp_err_e;

endpackage

// File: rtl/iob_vexriscv_dbus_bridge_if.sv
// Bus bundle between the VexRiscv dBus (cmd/rsp streams) and the IOb native bus.
//   cmd_*   : core command stream (valid/ready, wr, address, data, mask)
//   rsp_*   : core response stream (valid, data, error), no back-pressure
//   iob_*   : IOb request (valid, addr, wdata, wstrb) and completion (ready, rdata)
// Modports: slave = the bridge, master = the core plus IOb slave environment.
interface iob_vexriscv_dbus_bridge_if
    import iob_vexriscv_dbus_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_address;
    logic [DATA_W-1:0] cmd_data;
    logic [STRB_W-1:0] cmd_mask;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_error;

    logic              iob_valid;
    logic [ADDR_W-1:0] iob_addr;
    logic [DATA_W-1:0] iob_wdata;
    logic [STRB_W-1:0] iob_wstrb;
    logic              iob_ready;
    logic [DATA_W-1:0] iob_rdata;

    modport slave (
        input  cmd_valid, cmd_wr, cmd_address, cmd_data, cmd_mask,
        input  iob_ready, iob_rdata,
        output cmd_ready, rsp_valid, rsp_data, rsp_error,
        output iob_valid, iob_addr, iob_wdata, iob_wstrb
    );

    modport master (
        output cmd_valid, cmd_wr, cmd_address, cmd_data, cmd_mask,
        output iob_ready, iob_rdata,
        input  cmd_ready, rsp_valid, rsp_data, rsp_error,
        input  iob_valid, iob_addr, iob_wdata, iob_wstrb
    );

endinterface

// File: rtl/iob_vexriscv_dbus_bridge_watchdog.sv
// Saturating bus-timeout counter for the dBus bridge.
//   clk, rst  : clock, synchronous active-low reset
//   clear_i   : restart the count (a new access starts)
//   enable_i  : count this cycle (access waiting, no completion)
//   expiry_o  : combinational strobe, counter at all-ones while still waiting
// TIMEOUT_W == 0 removes the counter and ties expiry_o low.
module iob_vexriscv_dbus_bridge_watchdog
    import iob_vexriscv_dbus_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_W = TIMEOUT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expiry_o
);

    if (TIMEOUT_W == 0) begin : g_off
        assign expiry_o = 1'b0;
    end else begin : g_on
        logic [TIMEOUT_W-1:0] cnt_q;
        logic [TIMEOUT_W-1:0] cnt_d;

        // Clear wins over counting; hold at all-ones.
        always_comb begin
            cnt_d = cnt_q;
            if (clear_i) begin
                cnt_d = '0;
            end else if (enable_i && (cnt_q != '1)) begin
                cnt_d = cnt_q + TIMEOUT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign expiry_o = enable_i && (cnt_q == '1);
    end

endmodule

// File: rtl/iob_vexriscv_dbus_bridge.sv
// VexRiscv simple dBus to IOb native bus bridge, one access in flight.
//   clk, rst  : clock, synchronous active-low reset
//   bus       : dBus cmd/rsp and IOb request/completion signals (slave view)
//   timeout_o : one-cycle pulse when the watchdog aborts an access
// cmd_ready is combinational: high in IDLE, and in BUSY on the completion
// cycle so a following command is taken without a bubble.
module iob_vexriscv_dbus_bridge
    import iob_vexriscv_dbus_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned TIMEOUT_W = TIMEOUT_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    iob_vexriscv_dbus_bridge_if.slave   bus,
    output logic                        timeout_o
);

    localparam int unsigned STRB_W = DATA_W / 8;

    state_e            state_q,     state_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic [STRB_W-1:0] wstrb_q,     wstrb_d;
    logic              wr_q,        wr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
    rsp_err_e          rsp_err_q,   rsp_err_d;
    logic              timeout_q,   timeout_d;

    logic cmd_ready_c;
    logic accept_c;
    logic wd_enable_c;
    logic wd_expiry_c;

    // Watchdog counts BUSY cycles that see no completion.
    assign wd_enable_c = (state_q == STATE_BUSY) && !bus.iob_ready;

    iob_vexriscv_dbus_bridge_watchdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (accept_c),
        .enable_i (wd_enable_c),
        .expiry_o (wd_expiry_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        wr_d        = wr_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = RSP_ERR_NONE;
        timeout_d   = 1'b0;
        cmd_ready_c = 1'b0;
        accept_c    = 1'b0;

        case (state_q)
            STATE_IDLE: begin
                cmd_ready_c = 1'b1;
            end
            STATE_BUSY: begin
                // Completion has priority over a simultaneous expiry.
                if (bus.iob_ready) begin
                    cmd_ready_c = 1'b1;
                    state_d     = STATE_IDLE;
                    if (!wr_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = bus.iob_rdata;
                    end
                end else if (wd_expiry_c) begin
                    state_d   = STATE_IDLE;
                    timeout_d = 1'b1;
                    if (!wr_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_err_d   = RSP_ERR_TIMEOUT;
                    end
                end
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase

        accept_c = cmd_ready_c && bus.cmd_valid;
        if (accept_c) begin
            state_d = STATE_BUSY;
            addr_d  = bus.cmd_address;
            wdata_d = bus.cmd_data;
            wstrb_d = bus.cmd_wr ? bus.cmd_mask : '0;
            wr_d    = bus.cmd_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= STATE_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wr_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= RSP_ERR_NONE;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            wr_q        <= wr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_c;
    assign bus.iob_valid = (state_q == STATE_BUSY);
    assign bus.iob_addr  = addr_q;
    assign bus.iob_wdata = wdata_q;
    assign bus.iob_wstrb = wstrb_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_error = (rsp_err_q == RSP_ERR_TIMEOUT);
    assign timeout_o     = timeout_q;

endmodule
